// File: rtl/snax_cgra_csr_manager_if.sv
// CSR request/response stream between the SNAX accelerator shim and the
// CGRA CSR manager. Signal names carry the direction as seen by the manager.
interface snax_cgra_csr_manager_if;
    logic [63:0] csr_req_data_i;
    logic [31:0] csr_req_addr_i;
    logic        csr_req_write_i;
    logic        csr_req_valid_i;
    logic        csr_req_ready_o;
    logic        csr_rsp_valid_o;
    logic        csr_rsp_ready_i;
    logic [63:0] csr_rsp_data_o;

    modport master (
        output csr_req_data_i, csr_req_addr_i, csr_req_write_i, csr_req_valid_i,
        input  csr_req_ready_o,
        input  csr_rsp_valid_o, csr_rsp_data_o,
        output csr_rsp_ready_i
    );

    modport slave (
        input  csr_req_data_i, csr_req_addr_i, csr_req_write_i, csr_req_valid_i,
        output csr_req_ready_o,
        output csr_rsp_valid_o, csr_rsp_data_o,
        input  csr_rsp_ready_i
    );
endinterface

// File: rtl/snax_cgra_csr_manager.sv
// CGRA CSR register bank and launch controller: configuration registers,
// CTRL/STATUS/CYCLES registers, one-entry read response buffer, and an
// IDLE/BUSY launch FSM with a saturating run-cycle counter.
module snax_cgra_csr_manager #(
    parameter int unsigned NumCfgCsr = 8,
    parameter int unsigned CntWidth  = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    snax_cgra_csr_manager_if.slave    csr,
    output logic [NumCfgCsr*64-1:0]   cfg_o,
    output logic                      start_o,
    input  logic                      done_i,
    output logic                      busy_o
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic [31:0] ADDR_CTRL   = 32'(NumCfgCsr);
    localparam logic [31:0] ADDR_STATUS = 32'(NumCfgCsr + 1);
    localparam logic [31:0] ADDR_CYCLES = 32'(NumCfgCsr + 2);

    logic [0:0]          r_state;
    logic [63:0]         r_cfg [NumCfgCsr];
    logic [CntWidth-1:0] r_cnt;
    logic                r_start;
    logic                r_rsp_valid;
    logic [63:0]         r_rsp_data;

    logic        w_is_cfg;
    logic        w_is_ctrl;
    logic        w_is_status;
    logic        w_is_cycles;
    logic        w_busy;
    logic        w_ready;
    logic        w_wr_acc;
    logic        w_rd_acc;
    logic        w_launch;
    logic        w_rsp_pop;
    logic [63:0] w_rdata;

    assign w_is_cfg    = (csr.csr_req_addr_i < ADDR_CTRL);
    assign w_is_ctrl   = (csr.csr_req_addr_i == ADDR_CTRL);
    assign w_is_status = (csr.csr_req_addr_i == ADDR_STATUS);
    assign w_is_cycles = (csr.csr_req_addr_i == ADDR_CYCLES);
    assign w_busy      = (r_state == S_BUSY);

    // Request stall: no config/launch writes mid-run, no reads into a full buffer.
    always_comb begin
        w_ready = 1'b1;
        if (csr.csr_req_write_i && (w_is_cfg || w_is_ctrl) && w_busy) begin
            w_ready = 1'b0;
        end else if (!csr.csr_req_write_i && r_rsp_valid && !csr.csr_rsp_ready_i) begin
            w_ready = 1'b0;
        end
    end

    assign w_wr_acc  = csr.csr_req_valid_i && w_ready && csr.csr_req_write_i;
    assign w_rd_acc  = csr.csr_req_valid_i && w_ready && !csr.csr_req_write_i;
    assign w_launch  = w_wr_acc && w_is_ctrl && csr.csr_req_data_i[0] && !w_busy;
    assign w_rsp_pop = r_rsp_valid && csr.csr_rsp_ready_i;

    // Read data mux, sampled from pre-update state.
    always_comb begin
        w_rdata = '0;
        if (w_is_cfg) begin
            for (int unsigned k = 0; k < NumCfgCsr; k++) begin
                if (csr.csr_req_addr_i == 32'(k)) begin
                    w_rdata = r_cfg[k];
                end
            end
        end else if (w_is_status) begin
            w_rdata = {63'd0, w_busy};
        end else if (w_is_cycles) begin
            w_rdata = 64'(r_cnt);
        end
    end

    // Configuration register writes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned k = 0; k < NumCfgCsr; k++) begin
                r_cfg[k] <= '0;
            end
        end else if (w_wr_acc && w_is_cfg) begin
            for (int unsigned k = 0; k < NumCfgCsr; k++) begin
                if (csr.csr_req_addr_i == 32'(k)) begin
                    r_cfg[k] <= csr.csr_req_data_i;
                end
            end
        end
    end

    // Flatten configuration registers onto cfg_o.
    always_comb begin
        cfg_o = '0;
        for (int unsigned k = 0; k < NumCfgCsr; k++) begin
            cfg_o[64*k +: 64] = r_cfg[k];
        end
    end

    // Launch FSM, start pulse and saturating run-cycle counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_start <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_state <= S_BUSY;
                        r_start <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                S_BUSY: begin
                    if (done_i) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + CntWidth'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Single-entry response buffer; refill in the pop cycle keeps valid high.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else if (w_rd_acc) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_rdata;
        end else if (w_rsp_pop) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign csr.csr_req_ready_o = w_ready;
    assign csr.csr_rsp_valid_o = r_rsp_valid;
    assign csr.csr_rsp_data_o  = r_rsp_data;
    assign start_o             = r_start;
    assign busy_o              = w_busy;

endmodule

// File: tb/tb_snax_cgra_csr_manager.sv
// Randomized self-checking bench for snax_cgra_csr_manager with a
// transaction-level reference model (register array, response queue, run state).
module tb_snax_cgra_csr_manager;

    localparam int unsigned NCFG = 8;
    localparam int unsigned CW   = 6;
    localparam longint      CMAX = (64'd1 << CW) - 1;

    logic             clk;
    logic             rst_ni;
    logic [NCFG*64-1:0] cfg_o;
    logic             start_o;
    logic             done_i;
    logic             busy_o;

    snax_cgra_csr_manager_if bus ();

    snax_cgra_csr_manager #(.NumCfgCsr(NCFG), .CntWidth(CW)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .csr     (bus),
        .cfg_o   (cfg_o),
        .start_o (start_o),
        .done_i  (done_i),
        .busy_o  (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [63:0] m_cfg [NCFG];
    bit          m_busy;
    bit          m_start;
    longint      m_cnt;
    logic [63:0] m_q [$];

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NCFG; k++) m_cfg[k] = '0;
        m_busy = 0; m_start = 0; m_cnt = 0;
        m_q.delete();
    endtask

    function automatic logic [511:0] model_cfg();
        logic [511:0] v = '0;
        for (int k = 0; k < NCFG; k++) v[64*k +: 64] = m_cfg[k];
        return v;
    endfunction

    // One clock cycle: drive, check ready, clock, update model, check outputs.
    task automatic cyc(input bit v, input bit w, input logic [31:0] a,
                       input logic [63:0] d, input bit rr, input bit dn);
        bit          exp_rdy;
        bit          acc;
        logic [63:0] rd;
        bus.csr_req_valid_i = v;
        bus.csr_req_write_i = w;
        bus.csr_req_addr_i  = a;
        bus.csr_req_data_i  = d;
        bus.csr_rsp_ready_i = rr;
        done_i              = dn;
        #3;
        exp_rdy = 1;
        if (w && a <= NCFG && m_busy) exp_rdy = 0;
        else if (!w && m_q.size() != 0 && !rr) exp_rdy = 0;
        chk("req_ready", bus.csr_req_ready_o, exp_rdy);
        acc = v && exp_rdy;
        if (a < NCFG)          rd = m_cfg[a];
        else if (a == NCFG+1)  rd = 64'(m_busy);
        else if (a == NCFG+2)  rd = 64'(m_cnt);
        else                   rd = '0;
        @(posedge clk); #1;
        if (m_q.size() != 0 && rr) void'(m_q.pop_front());
        if (acc && !w) m_q.push_back(rd);
        m_start = 0;
        if (m_busy) begin
            if (dn) m_busy = 0;
            else if (m_cnt < CMAX) m_cnt++;
        end
        if (acc && w) begin
            if (a < NCFG) m_cfg[a] = d;
            if (a == NCFG && d[0] && !m_busy) begin
                m_busy = 1; m_start = 1; m_cnt = 0;
            end
        end
        chk("busy", busy_o, m_busy);
        chk("start", start_o, m_start);
        chk("rsp_valid", bus.csr_rsp_valid_o, m_q.size() != 0);
        if (m_q.size() != 0) chk("rsp_data", bus.csr_rsp_data_o, m_q[0]);
        chk("cfg", cfg_o, model_cfg());
    endtask

    task automatic idle(input int n, input bit rr);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, rr, 0);
    endtask

    int busy_cnt;

    initial begin
        rst_ni = 0;
        done_i = 0;
        bus.csr_req_valid_i = 0; bus.csr_req_write_i = 0;
        bus.csr_req_addr_i = 0;  bus.csr_req_data_i = 0;
        bus.csr_rsp_ready_i = 0;
        model_reset();

        // Reset state
        #12;
        chk("rst_busy", busy_o, 0);
        chk("rst_start", start_o, 0);
        chk("rst_rsp_valid", bus.csr_rsp_valid_o, 0);
        chk("rst_rsp_data", bus.csr_rsp_data_o, 0);
        chk("rst_cfg", cfg_o, 0);
        bus.csr_req_write_i = 1; bus.csr_req_addr_i = NCFG; #1;
        chk("rst_ready_wr", bus.csr_req_ready_o, 1);
        bus.csr_req_write_i = 0; #1;
        chk("rst_ready_rd", bus.csr_req_ready_o, 1);
        @(posedge clk); #1;
        rst_ni = 1;

        // 1: CFG write then read
        cyc(1, 1, 3, 64'hDEADBEEF_01234567, 1, 0);
        chk("t1_cfg3", cfg_o[255:192], 64'hDEADBEEF_01234567);
        chk("t1_no_wr_rsp", bus.csr_rsp_valid_o, 0);
        cyc(1, 0, 3, 0, 1, 0);
        chk("t1_rsp", bus.csr_rsp_data_o, 64'hDEADBEEF_01234567);
        idle(1, 1);

        // 2: launch, 10 cycles, done, read CYCLES and STATUS
        cyc(1, 1, NCFG, 1, 1, 0);
        chk("t2_start", start_o, 1);
        busy_cnt = busy_o;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 0, 1, 0);
            busy_cnt += busy_o;
            chk("t2_start_low", start_o, 0);
        end
        cyc(0, 0, 0, 0, 1, 1);
        busy_cnt += busy_o;
        chk("t2_busy_cycles", busy_cnt, 11);
        cyc(1, 0, NCFG+2, 0, 1, 0);
        chk("t2_cycles", bus.csr_rsp_data_o, 10);
        cyc(1, 0, NCFG+1, 0, 1, 0);
        chk("t2_status", bus.csr_rsp_data_o, 0);
        idle(1, 1);

        // 3: writes stall while BUSY, accepted after done
        cyc(1, 1, NCFG, 1, 1, 0);
        cyc(1, 1, 0, 64'h1111, 1, 0);
        chk("t3_cfg0_stalled", cfg_o[63:0], 0);
        cyc(1, 1, NCFG, 1, 1, 0);
        cyc(1, 1, 0, 64'h1111, 1, 1);
        cyc(1, 1, 0, 64'h1111, 1, 0);
        chk("t3_cfg0", cfg_o[63:0], 64'h1111);
        cyc(1, 1, NCFG, 1, 1, 0);
        chk("t3_start2", start_o, 1);
        cyc(0, 0, 0, 0, 1, 1);

        // 4: back-to-back reads with response backpressure
        cyc(1, 0, 3, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0, 0, 0);
            chk("t4_hold", bus.csr_rsp_data_o, 64'hDEADBEEF_01234567);
        end
        cyc(1, 0, 0, 0, 1, 0);
        chk("t4_second", bus.csr_rsp_data_o, 64'h1111);
        idle(1, 1);

        // 5: out-of-range address
        cyc(1, 0, NCFG+7, 0, 1, 0);
        chk("t5_oor_rd", bus.csr_rsp_data_o, 0);
        cyc(1, 1, NCFG, 1, 1, 0);
        cyc(1, 1, NCFG+7, '1, 1, 0);
        cyc(0, 0, 0, 0, 1, 1);

        // Counter saturation
        cyc(1, 1, NCFG, 1, 1, 0);
        idle(70, 1);
        cyc(1, 0, NCFG+2, 0, 1, 0);
        chk("sat_cycles", bus.csr_rsp_data_o, CMAX);
        cyc(0, 0, 0, 0, 1, 1);

        // 6: reset mid-run with a pending response
        cyc(1, 1, 5, 64'h55AA, 1, 0);
        cyc(1, 1, NCFG, 1, 1, 0);
        cyc(1, 0, 5, 0, 0, 0);
        #1 rst_ni = 0;
        #1;
        chk("t6_busy", busy_o, 0);
        chk("t6_rsp_valid", bus.csr_rsp_valid_o, 0);
        chk("t6_cfg", cfg_o, 0);
        model_reset();
        @(posedge clk); #1;
        rst_ni = 1;
        cyc(0, 0, 0, 0, 1, 1);
        chk("t6_done_ignored", busy_o, 0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] a;
            logic [63:0] d;
            a = (($urandom_range(0, 15) == 0) ? 32'($urandom_range(NCFG+3, 40))
                                               : 32'($urandom_range(0, NCFG+2)));
            d = {$urandom, $urandom};
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, a, d,
                $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
